// File: rtl/pacman_pkg.sv
// pacman_pkg: shared maze types and constants for the Pac-Man tile logic.
//   Tile codes  : WALL, WKNP (walkable, no pellet), WKRP (walkable, pellet), WKGH (ghost house)
//   Directions  : RIGHT=0, UP=1, DOWN=2, LEFT=3
//   MAZE_INIT   : power-on / level-start tile map, MAZE_INIT[y][x]
//   PELLET_TOTAL: number of WKRP tiles in MAZE_INIT
//   norm_tile() : on-board test and column normalisation for a raw tile coordinate
// Build option: TUNNEL_WRAP_EN makes columns -1 and 28 wrap to 27 and 0.
package pacman_pkg;

  localparam int unsigned MAZE_W = 28;
  localparam int unsigned MAZE_H = 31;

  typedef enum logic [1:0] {
    WALL = 2'd0,
    WKNP = 2'd1,
    WKRP = 2'd2,
    WKGH = 2'd3
  } tile_e;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_e;

  typedef enum logic {
    StPlay  = 1'b0,
    StClear = 1'b1
  } state_e;

  typedef logic [MAZE_H-1:0][MAZE_W-1:0][1:0] maze_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] x;
    logic [4:0] y;
  } tile_pos_t;

  // Wall layout, one row per entry; the leftmost digit is column 0.
  localparam logic [MAZE_W-1:0] WALL_ROWS [MAZE_H] = '{
    28'b1111111111111111111111111111,  // 0
    28'b1000000000000110000000000001,  // 1
    28'b1011110111110110111110111101,  // 2
    28'b1011110111110110111110111101,  // 3
    28'b1011110111110110111110111101,  // 4
    28'b1000000000000000000000000001,  // 5
    28'b1011110110111111110110111101,  // 6
    28'b1011110110111111110110111101,  // 7
    28'b1000000110000110000110000001,  // 8
    28'b1111110111110110111110111111,  // 9
    28'b1111110111110110111110111111,  // 10
    28'b1111110110000000000110111111,  // 11
    28'b1111110110111001110110111111,  // 12
    28'b1111110110100000010110111111,  // 13
    28'b0000000000100000010000000000,  // 14 tunnel row
    28'b1111110110100000010110111111,  // 15
    28'b1111110110111111110110111111,  // 16
    28'b1111110110000000000110111111,  // 17
    28'b1111110110111111110110111111,  // 18
    28'b1111110110111111110110111111,  // 19
    28'b1000000000000110000000000001,  // 20
    28'b1011110111110110111110111101,  // 21
    28'b1011110111110110111110111101,  // 22
    28'b1000110000000000000000110001,  // 23
    28'b1110110110111111110110110111,  // 24
    28'b1110110110111111110110110111,  // 25
    28'b1000000110000110000110000001,  // 26
    28'b1011111111110110111111111101,  // 27
    28'b1011111111110110111111111101,  // 28
    28'b1000000000000000000000000001,  // 29
    28'b1111111111111111111111111111   // 30
  };

  // Open floor is a pellet unless it is the ghost house (interior plus door) or
  // part of the bare centre band / start position.
  function automatic maze_t build_maze();
    maze_t m;
    for (int y = 0; y < int'(MAZE_H); y++) begin
      for (int x = 0; x < int'(MAZE_W); x++) begin
        if (WALL_ROWS[5'(y)][5'(int'(MAZE_W) - 1 - x)]) begin
          m[5'(y)][5'(x)] = WALL;
        end else if ((y >= 13 && y <= 15 && x >= 11 && x <= 16) ||
                     (y == 12 && (x == 13 || x == 14))) begin
          m[5'(y)][5'(x)] = WKGH;
        end else if ((y >= 9 && y <= 19 && x != 6 && x != 21) ||
                     (y == 23 && (x == 13 || x == 14))) begin
          m[5'(y)][5'(x)] = WKNP;
        end else begin
          m[5'(y)][5'(x)] = WKRP;
        end
      end
    end
    return m;
  endfunction

  function automatic int unsigned count_pellets(maze_t m);
    int unsigned n = 0;
    for (int y = 0; y < int'(MAZE_H); y++) begin
      for (int x = 0; x < int'(MAZE_W); x++) begin
        if (m[5'(y)][5'(x)] == WKRP) n++;
      end
    end
    return n;
  endfunction

  localparam maze_t       MAZE_INIT    = build_maze();
  localparam int unsigned PELLET_TOTAL = count_pellets(MAZE_INIT);

  // Raw 7-bit coordinates: values past the board (including -1 as 127) are off-board,
  // except the two tunnel columns when wrapping is built in.
  function automatic tile_pos_t norm_tile(logic [6:0] x, logic [6:0] y);
    tile_pos_t  p;
    logic [6:0] cx;
    cx = x;
`ifdef TUNNEL_WRAP_EN
    if (x == 7'd127) begin
      cx = 7'(MAZE_W - 1);
    end else if (x == 7'(MAZE_W)) begin
      cx = 7'd0;
    end
`endif
    p.valid = (cx < 7'(MAZE_W)) && (y < 7'(MAZE_H));
    p.x     = p.valid ? cx[4:0] : 5'd0;
    p.y     = p.valid ? y[4:0] : 5'd0;
    return p;
  endfunction

endpackage

// File: rtl/maze_neighbour.sv
// maze_neighbour: combinational neighbour address generator.
//   x, y  : raw Pac-Man tile coordinate (7 bits each)
//   dir   : RIGHT/UP/DOWN/LEFT
//   valid : own tile and neighbour both on-board
//   nx, ny: neighbour coordinate (zero when not valid)
// Build option: TUNNEL_WRAP_EN (via pacman_pkg::norm_tile) enables column wrap.
module maze_neighbour
  import pacman_pkg::*;
(
  input  logic [6:0] x,
  input  logic [6:0] y,
  input  logic [1:0] dir,
  output logic       valid,
  output logic [4:0] nx,
  output logic [4:0] ny
);

  tile_pos_t  own;
  tile_pos_t  nbr;
  logic [6:0] rx;
  logic [6:0] ry;

  always_comb begin
    own = norm_tile(x, y);
    rx  = {2'b00, own.x};
    ry  = {2'b00, own.y};
    // Stepping off row 0 or column 0 underflows to 127, which norm_tile treats as -1.
    case (dir_e'(dir))
      RIGHT: rx = rx + 7'd1;
      UP:    ry = ry - 7'd1;
      DOWN:  ry = ry + 7'd1;
      LEFT:  rx = rx - 7'd1;
    endcase
    nbr   = norm_tile(rx, ry);
    valid = own.valid && nbr.valid;
    nx    = nbr.x;
    ny    = nbr.y;
  end

endmodule

// File: rtl/maze_state.sv
// maze_state: live maze tile map for one game.
//   clk60        : game clock
//   reset        : synchronous active-high; reload map, clear score, enter PLAY
//   restart      : next-level reload, score kept
//   active       : movement block in NORMAL; gates eating
//   pac_xtile/ytile : Pac-Man tile coordinate
//   tile_info[0:3]  : registered neighbour tiles, index = RIGHT/UP/DOWN/LEFT
//   score, pellets_left, eat_pulse, level_clear : game progress
// Build option: TUNNEL_WRAP_EN enables left/right tunnel wrap.
module maze_state
  import pacman_pkg::*;
#(
  parameter int unsigned PELLET_POINTS = 10
) (
  input  logic        clk60,
  input  logic        reset,
  input  logic        restart,
  input  logic        active,
  input  logic [6:0]  pac_xtile,
  input  logic [6:0]  pac_ytile,
  output logic [1:0]  tile_info [0:3],
  output logic [15:0] score,
  output logic [7:0]  pellets_left,
  output logic        eat_pulse,
  output logic        level_clear
);

  maze_t       map_q;
  state_e      state_q;
  tile_pos_t   own;
  logic [3:0]  nbr_valid;
  logic [4:0]  nbr_x    [0:3];
  logic [4:0]  nbr_y    [0:3];
  logic [1:0]  nbr_tile [0:3];
  logic        eat;
  logic [16:0] score_sum;
  logic [15:0] score_sat;

  for (genvar d = 0; d < 4; d++) begin : g_nbr
    maze_neighbour u_nbr (
      .x     (pac_xtile),
      .y     (pac_ytile),
      .dir   (2'(d)),
      .valid (nbr_valid[d]),
      .nx    (nbr_x[d]),
      .ny    (nbr_y[d])
    );
    assign nbr_tile[d] = nbr_valid[d] ? map_q[nbr_y[d]][nbr_x[d]] : WALL;
  end

  always_comb begin
    own       = norm_tile(pac_xtile, pac_ytile);
    eat       = (state_q == StPlay) && active && own.valid &&
                (map_q[own.y][own.x] == WKRP);
    score_sum = {1'b0, score} + 17'(PELLET_POINTS);
    score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  assign level_clear = (state_q == StClear);

  always_ff @(posedge clk60) begin
    if (reset) begin
      map_q        <= MAZE_INIT;
      state_q      <= StPlay;
      score        <= '0;
      pellets_left <= 8'(PELLET_TOTAL);
      eat_pulse    <= 1'b0;
      for (int d = 0; d < 4; d++) tile_info[d] <= WALL;
    end else begin
      // Lookup uses the map as it stands now, so a pellet cleared on this edge
      // shows up one edge later, together with the new position.
      for (int d = 0; d < 4; d++) tile_info[d] <= nbr_tile[d];
      eat_pulse <= 1'b0;
      if (restart) begin
        // A coincident eat is dropped: the reload wins and the score stays.
        map_q        <= MAZE_INIT;
        state_q      <= StPlay;
        pellets_left <= 8'(PELLET_TOTAL);
      end else begin
        if (state_q == StPlay && pellets_left == 8'd0) begin
          state_q <= StClear;
        end
        if (eat) begin
          map_q[own.y][own.x] <= WKNP;
          score               <= score_sat;
          pellets_left        <= pellets_left - 8'd1;
          eat_pulse           <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maze_state.sv
// tb_maze_state: scoreboard bench for maze_state. Each cycle a reference model
// predicts the outputs after the next edge; the prediction is queued when the
// stimulus is driven and popped and compared once the edge has passed.
// Build option: TUNNEL_WRAP_EN must match the RTL build.
module tb_maze_state;
  import pacman_pkg::*;

  localparam int PTS = 10;

  logic        clk60 = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic        active = 1'b0;
  logic [6:0]  pac_xtile = 7'd1;
  logic [6:0]  pac_ytile = 7'd1;
  logic [1:0]  tile_info [0:3];
  logic [15:0] score;
  logic [7:0]  pellets_left;
  logic        eat_pulse;
  logic        level_clear;

  maze_state #(
    .PELLET_POINTS (PTS)
  ) dut (
    .clk60        (clk60),
    .reset        (reset),
    .restart      (restart),
    .active       (active),
    .pac_xtile    (pac_xtile),
    .pac_ytile    (pac_ytile),
    .tile_info    (tile_info),
    .score        (score),
    .pellets_left (pellets_left),
    .eat_pulse    (eat_pulse),
    .level_clear  (level_clear)
  );

  always #5 clk60 = ~clk60;

  typedef struct packed {
    logic [3:0][1:0] ti;
    logic [15:0]     score;
    logic [7:0]      pellets;
    logic            eat;
    logic            clr;
  } exp_t;

  exp_t       sb_q [$];
  logic [1:0] m_map [31][28];
  int         m_score;
  int         m_pellets;
  bit         m_clear;
  int         exp_total;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic m_reload();
    for (int y = 0; y < 31; y++)
      for (int x = 0; x < 28; x++) m_map[y][x] = MAZE_INIT[y][x];
    m_pellets = exp_total;
  endtask

  function automatic logic [1:0] m_tile(int x, int y);
    int cx = x;
`ifdef TUNNEL_WRAP_EN
    if (cx == -1) cx = 27;
    else if (cx == 28) cx = 0;
`endif
    if (cx < 0 || cx > 27 || y < 0 || y > 30) return WALL;
    return m_map[y][cx];
  endfunction

  // Predict, push, clock, pop, compare.
  task automatic step();
    exp_t e;
    int   ox, oy;
    bit   own_ok, go_clear, do_eat;
    ox = (pac_xtile == 7'd127) ? -1 : int'(pac_xtile);
    oy = (pac_ytile == 7'd127) ? -1 : int'(pac_ytile);
`ifdef TUNNEL_WRAP_EN
    if (ox == -1) ox = 27;
    else if (ox == 28) ox = 0;
`endif
    own_ok = ox >= 0 && ox < 28 && oy >= 0 && oy < 31;
    for (int d = 0; d < 4; d++) e.ti[d] = WALL;
    if (!reset && own_ok) begin
      e.ti[0] = m_tile(ox + 1, oy);
      e.ti[1] = m_tile(ox, oy - 1);
      e.ti[2] = m_tile(ox, oy + 1);
      e.ti[3] = m_tile(ox - 1, oy);
    end
    do_eat = 1'b0;
    if (reset) begin
      m_reload();
      m_score = 0;
      m_clear = 1'b0;
    end else if (restart) begin
      m_reload();
      m_clear = 1'b0;
    end else begin
      go_clear = !m_clear && m_pellets == 0;
      if (own_ok) do_eat = !m_clear && active && m_map[oy][ox] == WKRP;
      if (do_eat) begin
        m_map[oy][ox] = WKNP;
        m_score = (m_score + PTS > 65535) ? 65535 : m_score + PTS;
        m_pellets--;
      end
      if (go_clear) m_clear = 1'b1;
    end
    e.score   = 16'(m_score);
    e.pellets = 8'(m_pellets);
    e.eat     = do_eat;
    e.clr     = m_clear;
    sb_q.push_back(e);
    @(posedge clk60);
    #1;
    e = sb_q.pop_front();
    for (int d = 0; d < 4; d++) check_eq($sformatf("sb_tile%0d", d), tile_info[d], e.ti[d]);
    check_eq("sb_score", score, e.score);
    check_eq("sb_pellets", pellets_left, e.pellets);
    check_eq("sb_eat_pulse", eat_pulse, e.eat);
    check_eq("sb_level_clear", level_clear, e.clr);
  endtask

  task automatic clear_level();
    active = 1'b1;
    for (int y = 0; y < 31; y++) begin
      for (int x = 0; x < 28; x++) begin
        if (m_map[y][x] == WKRP) begin
          pac_xtile = 7'(x);
          pac_ytile = 7'(y);
          step();
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lv;
    exp_total = 0;
    for (int y = 0; y < 31; y++)
      for (int x = 0; x < 28; x++) if (MAZE_INIT[y][x] == WKRP) exp_total++;
    m_reload();
    m_score = 0;
    m_clear = 1'b0;

    // Reset, then neighbours of (1,1).
    step();
    reset = 1'b0;
    step();
    check_eq("init_right", tile_info[0], WKRP);
    check_eq("init_up", tile_info[1], WALL);
    check_eq("init_down", tile_info[2], WKRP);
    check_eq("init_left", tile_info[3], WALL);
    check_eq("init_score", score, 0);
    check_eq("init_pellets", pellets_left, exp_total);

    // First eat, then hold.
    active = 1'b1;
    step();
    check_eq("eat1_pulse", eat_pulse, 1);
    check_eq("eat1_score", score, 10);
    check_eq("eat1_pellets", pellets_left, exp_total - 1);
    repeat (5) step();
    check_eq("hold_score", score, 10);
    check_eq("hold_pulse", eat_pulse, 0);

    // Move right and back: no re-eat of (1,1).
    pac_xtile = 7'd2;
    step();
    check_eq("move_left_cleared", tile_info[3], WKNP);
    check_eq("move_score", score, 20);
    pac_xtile = 7'd1;
    step();
    step();
    check_eq("back_score", score, 20);

    // Tunnel row and off-board rows.
    active    = 1'b0;
    pac_xtile = 7'd0;
    pac_ytile = 7'd14;
    step();
`ifdef TUNNEL_WRAP_EN
    check_eq("tunnel_left", tile_info[3], WKNP);
`else
    check_eq("tunnel_left", tile_info[3], WALL);
`endif
    check_eq("tunnel_right", tile_info[0], WKNP);
    pac_xtile = 7'd127;
    step();
`ifdef TUNNEL_WRAP_EN
    check_eq("tunnel_m1_right", tile_info[0], WKNP);
`else
    check_eq("tunnel_m1_right", tile_info[0], WALL);
`endif
    pac_xtile = 7'd1;
    pac_ytile = 7'd127;
    step();
    for (int d = 0; d < 4; d++) check_eq($sformatf("offboard_tile%0d", d), tile_info[d], WALL);
    pac_ytile = 7'd31;
    step();

    // Restart collides with an eat.
    pac_xtile = 7'd1;
    pac_ytile = 7'd5;
    active    = 1'b1;
    restart   = 1'b1;
    step();
    check_eq("rst_eat_score", score, 20);
    check_eq("rst_eat_pulse", eat_pulse, 0);
    check_eq("rst_eat_pellets", pellets_left, exp_total);
    restart   = 1'b0;
    active    = 1'b0;
    pac_xtile = 7'd2;
    pac_ytile = 7'd1;
    step();
    check_eq("reload_left", tile_info[3], WKRP);

    // Clear the whole board.
    clear_level();
    check_eq("clear_pellets", pellets_left, 0);
    check_eq("clear_flag_early", level_clear, 0);
    check_eq("clear_score", score, 20 + PTS * exp_total);
    step();
    check_eq("clear_flag", level_clear, 1);
    restart = 1'b1;
    active  = 1'b0;
    step();
    restart = 1'b0;
    check_eq("next_level_flag", level_clear, 0);
    check_eq("next_level_score", score, 20 + PTS * exp_total);
    check_eq("next_level_pellets", pellets_left, exp_total);

    // Keep clearing levels until the score saturates.
    lv = 0;
    while (m_score < 65535 && lv < 40) begin
      clear_level();
      step();
      restart = 1'b1;
      active  = 1'b0;
      step();
      restart = 1'b0;
      lv++;
    end
    check_eq("sat_score", score, 65535);

    // Mid-level reset discards progress.
    pac_xtile = 7'd1;
    pac_ytile = 7'd1;
    active    = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset  = 1'b0;
    active = 1'b0;
    step();
    check_eq("reset_score", score, 0);
    check_eq("reset_pellets", pellets_left, exp_total);
    check_eq("reset_right", tile_info[0], WKRP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
